mem_access_ctrl: RTL and testbench

- Multi-cycle load/store sequencer between the MEM pipeline stage and an external data-RAM bus.
- Accepts one memory operation at a time and drives a req/ack bus with byte-lane selects.
- Holds the pipeline via stall_request until the access completes.
- Returns sign/zero-extended load data, and flags misaligned accesses and bus timeouts.

---
 rtl/mem_access_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer from the MEM stage onto a req/ack data-RAM bus; 3 cycles minimum (IDLE, BUS, DONE).
// Backpressure: stall_request holds the pipeline until DONE; the bus holds the request until bus_ack or timeout.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_store,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_store_data,
  output logic        stall_request,
  output logic        result_valid,
  output logic [31:0] result_data,
  output logic        misaligned,
  output logic        timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state, state_nxt;
  logic [9:0]  wait_cnt;
  logic        lat_store, lat_unsigned;
  logic [1:0]  lat_size, lat_off;
  logic        op_misaligned, expired;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c, load_ext;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    op_misaligned = 1'b0;
    case (op_size)
      2'b01:   op_misaligned = op_addr[0];
      2'b10:   op_misaligned = |op_addr[1:0];
      2'b11:   op_misaligned = 1'b1;
      default: op_misaligned = 1'b0;
    endcase
  end

  // Big-endian lanes: byte offset 0 lives in bits 31:24.
  always_comb begin
    sel_c   = 4'b1111;
    wdata_c = op_store_data;
    case (op_size)
      2'b00: begin
        sel_c   = 4'b1000 >> op_addr[1:0];
        wdata_c = {4{op_store_data[7:0]}};
      end
      2'b01: begin
        sel_c   = op_addr[1] ? 4'b0011 : 4'b1100;
        wdata_c = {2{op_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b = bus_rdata[31:24];
    case (lat_off)
      2'd1:    lane_b = bus_rdata[23:16];
      2'd2:    lane_b = bus_rdata[15:8];
      2'd3:    lane_b = bus_rdata[7:0];
      default: ;
    endcase
    lane_h   = lat_off[1] ? bus_rdata[15:0] : bus_rdata[31:16];
    load_ext = bus_rdata;
    case (lat_size)
      2'b00:   load_ext = {{24{~lat_unsigned & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~lat_unsigned & lane_h[15]}}, lane_h};
      default: load_ext = bus_rdata;
    endcase
  end

  // An ack arriving on the expiry cycle takes priority over the abort.
  always_comb begin
    state_nxt     = state;
    expired       = (state == BUS) && !bus_ack && (wait_cnt == WAIT_LAST);
    stall_request = ((state == IDLE) && op_valid) || (state == BUS);
    case (state)
      IDLE:    if (op_valid) state_nxt = op_misaligned ? DONE : BUS;
      BUS:     if (bus_ack || expired) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      lat_store    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= '0;
      lat_off      <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
      misaligned   <= 1'b0;
      timeout      <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_sel      <= '0;
      bus_wdata    <= '0;
    end else begin
      state        <= state_nxt;
      result_valid <= 1'b0;
      misaligned   <= 1'b0;
      timeout      <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (op_valid) begin
            if (op_misaligned) begin
              misaligned <= 1'b1;
            end else begin
              bus_req      <= 1'b1;
              bus_we       <= op_store;
              bus_addr     <= {op_addr[31:2], 2'b00};
              bus_sel      <= sel_c;
              bus_wdata    <= wdata_c;
              lat_store    <= op_store;
              lat_unsigned <= op_unsigned;
              lat_size     <= op_size;
              lat_off      <= op_addr[1:0];
            end
          end
        end
        BUS: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            if (!lat_store) begin
              result_valid <= 1'b1;
              result_data  <= load_ext;
            end
          end else if (expired) begin
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            timeout     <= 1'b1;
            result_data <= '0;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized ops against a transaction-level model.
// Two instances: default timeout, and TIMEOUT_CYCLES = 4; only the selected one sees op_valid/bus_ack.
module tb_mem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0, op_store = 1'b0, op_unsigned = 1'b0, bus_ack = 1'b0;
  logic [1:0]  op_size = '0;
  logic [31:0] op_addr = '0, op_store_data = '0, bus_rdata = '0;
  logic        use_t4 = 1'b0;

  logic        op_valid_m, op_valid_t, bus_ack_m, bus_ack_t;
  logic        m_stall, m_rv, m_mis, m_to, m_req, m_we;
  logic [31:0] m_rd, m_addr, m_wdata;
  logic [3:0]  m_sel;
  logic        t_stall, t_rv, t_mis, t_to, t_req, t_we;
  logic [31:0] t_rd, t_addr, t_wdata;
  logic [3:0]  t_sel;
  logic        obs_stall, obs_rv, obs_mis, obs_to, obs_req, obs_we;
  logic [31:0] obs_rd, obs_addr, obs_wdata;
  logic [3:0]  obs_sel;

  assign op_valid_m = op_valid & ~use_t4;
  assign op_valid_t = op_valid & use_t4;
  assign bus_ack_m  = bus_ack & ~use_t4;
  assign bus_ack_t  = bus_ack & use_t4;
  assign obs_stall  = use_t4 ? t_stall : m_stall;
  assign obs_rv     = use_t4 ? t_rv    : m_rv;
  assign obs_mis    = use_t4 ? t_mis   : m_mis;
  assign obs_to     = use_t4 ? t_to    : m_to;
  assign obs_req    = use_t4 ? t_req   : m_req;
  assign obs_we     = use_t4 ? t_we    : m_we;
  assign obs_rd     = use_t4 ? t_rd    : m_rd;
  assign obs_addr   = use_t4 ? t_addr  : m_addr;
  assign obs_wdata  = use_t4 ? t_wdata : m_wdata;
  assign obs_sel    = use_t4 ? t_sel   : m_sel;

  mem_access_ctrl dut (
    .clock(clock), .reset(reset), .op_valid(op_valid_m), .op_store(op_store), .op_size(op_size),
    .op_unsigned(op_unsigned), .op_addr(op_addr), .op_store_data(op_store_data),
    .stall_request(m_stall), .result_valid(m_rv), .result_data(m_rd), .misaligned(m_mis), .timeout(m_to),
    .bus_req(m_req), .bus_we(m_we), .bus_addr(m_addr), .bus_sel(m_sel), .bus_wdata(m_wdata),
    .bus_ack(bus_ack_m), .bus_rdata(bus_rdata)
  );

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut_t4 (
    .clock(clock), .reset(reset), .op_valid(op_valid_t), .op_store(op_store), .op_size(op_size),
    .op_unsigned(op_unsigned), .op_addr(op_addr), .op_store_data(op_store_data),
    .stall_request(t_stall), .result_valid(t_rv), .result_data(t_rd), .misaligned(t_mis), .timeout(t_to),
    .bus_req(t_req), .bus_we(t_we), .bus_addr(t_addr), .bus_sel(t_sel), .bus_wdata(t_wdata),
    .bus_ack(bus_ack_t), .bus_rdata(bus_rdata)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  // Observations of the most recent operation
  int          o_stall, o_bus, o_rv, o_mis, o_to;
  logic        o_done, o_stable, o_we;
  logic [31:0] o_res, o_addr, o_wdata;
  logic [3:0]  o_sel;

  // Transaction-level reference: what one op should produce, from the architectural rules only.
  function automatic void model(input logic st, input logic [1:0] sz, input logic un,
                                input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rdata,
                                input int ack_at, input int to_n,
                                output logic e_mis, output logic [3:0] e_sel, output logic [31:0] e_wdata,
                                output logic [31:0] e_res, output logic e_rv, output logic e_to,
                                output int e_bus, output int e_stall);
    int off, nb;
    logic completes;
    logic [63:0] mask, v;
    off = int'(addr[1:0]);
    e_mis = (sz == 2'd3) || (sz == 2'd1 && (off % 2) == 1) || (sz == 2'd2 && off != 0);
    e_sel = '0; e_wdata = '0; e_res = '0; e_rv = 1'b0; e_to = 1'b0; e_bus = 0; e_stall = 1;
    if (e_mis) return;
    nb = 1 << sz;
    e_sel = 4'(((1 << nb) - 1) << (4 - nb - off));
    e_wdata = (nb == 1) ? (data & 32'hFF) * 32'h0101_0101 :
              (nb == 2) ? (data & 32'hFFFF) * 32'h0001_0001 : data;
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v = ({32'd0, rdata} >> (8 * (4 - nb - off))) & mask;
    if (!un && v[8 * nb - 1]) v = v | ~mask;
    completes = (ack_at >= 1) && (ack_at <= to_n);
    e_bus   = completes ? ack_at : to_n;
    e_to    = !completes;
    e_rv    = completes && !st;
    e_res   = e_to ? 32'd0 : v[31:0];
    e_stall = 1 + e_bus;
  endfunction

  // Presents one op to the selected instance, answers the bus on BUS cycle ack_at (0 = never), records what happened.
  task automatic run_op(input logic st, input logic [1:0] sz, input logic un, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] rdata, input int ack_at);
    o_stall = 0; o_bus = 0; o_rv = 0; o_mis = 0; o_to = 0; o_done = 1'b0; o_stable = 1'b1;
    o_res = '0; o_addr = '0; o_wdata = '0; o_sel = '0; o_we = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clock); #1;
      if (cyc == 0) begin
        op_valid = 1'b1; op_store = st; op_size = sz; op_unsigned = un;
        op_addr = addr; op_store_data = data; bus_rdata = rdata;
      end
      bus_ack = obs_req && (o_bus + 1 == ack_at);
      @(negedge clock);
      if (obs_req) begin
        if (o_bus == 0) begin
          o_addr = obs_addr; o_sel = obs_sel; o_we = obs_we; o_wdata = obs_wdata;
        end else if ({obs_addr, obs_sel, obs_we, obs_wdata} !== {o_addr, o_sel, o_we, o_wdata}) begin
          o_stable = 1'b0;
        end
        o_bus++;
      end
      if (obs_stall) o_stall++;
      if (obs_rv)    o_rv++;
      if (obs_mis)   o_mis++;
      if (obs_to)    o_to++;
      if (!obs_stall) begin
        o_done = 1'b1;
        o_res  = obs_rd;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      op_valid = 1'b0; bus_ack = 1'b0;
    end
  endtask

  task automatic test_reset;
    @(negedge clock);
    tests_run++;
    if ({m_stall, m_req, m_we, m_addr, m_sel, m_wdata, m_rv, m_rd, m_mis, m_to} !== '0) begin
      tests_failed++; $display("FAIL reset_main: outputs %h %h %h %h %h %h %h %h %h %h want all 0",
                               m_stall, m_req, m_we, m_addr, m_sel, m_wdata, m_rv, m_rd, m_mis, m_to);
    end
    tests_run++;
    if ({t_stall, t_req, t_we, t_addr, t_sel, t_wdata, t_rv, t_rd, t_mis, t_to} !== '0) begin
      tests_failed++; $display("FAIL reset_t4: some output nonzero (req=%b rd=%h sel=%h)", t_req, t_rd, t_sel);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_word_load;
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 1);
    tests_run++;
    if ({o_addr, o_sel, o_we} !== {32'h0000_1004, 4'b1111, 1'b0}) begin
      tests_failed++; $display("FAIL word_bus: addr=%h sel=%b we=%b want 00001004 1111 0", o_addr, o_sel, o_we);
    end
    tests_run++;
    if (o_rv !== 1 || o_res !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL word_result: pulses=%0d data=%h want 1 deadbeef", o_rv, o_res);
    end
    tests_run++;
    if (o_stall !== 2 || o_done !== 1'b1) begin
      tests_failed++; $display("FAIL word_stall: stall=%0d done=%b want 2 1", o_stall, o_done);
    end
  endtask

  task automatic test_byte_loads;
    run_op(1'b0, 2'd0, 1'b0, 32'h0000_1002, 32'h0, 32'h1122_8344, 1);
    tests_run++;
    if (o_sel !== 4'b0010 || o_res !== 32'hFFFF_FF83 || o_rv !== 1) begin
      tests_failed++; $display("FAIL lb: sel=%b data=%h pulses=%0d want 0010 ffffff83 1", o_sel, o_res, o_rv);
    end
    run_op(1'b0, 2'd0, 1'b1, 32'h0000_1002, 32'h0, 32'h1122_8344, 1);
    tests_run++;
    if (o_sel !== 4'b0010 || o_res !== 32'h0000_0083 || o_rv !== 1) begin
      tests_failed++; $display("FAIL lbu: sel=%b data=%h pulses=%0d want 0010 00000083 1", o_sel, o_res, o_rv);
    end
  endtask

  task automatic test_half_store;
    run_op(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 5);
    tests_run++;
    if ({o_we, o_sel, o_wdata, o_addr} !== {1'b1, 4'b0011, 32'hABCD_ABCD, 32'h0000_2000}) begin
      tests_failed++; $display("FAIL sh_bus: we=%b sel=%b wdata=%h addr=%h want 1 0011 abcdabcd 00002000",
                               o_we, o_sel, o_wdata, o_addr);
    end
    tests_run++;
    if (o_stable !== 1'b1 || o_bus !== 5) begin
      tests_failed++; $display("FAIL sh_hold: stable=%b bus_cycles=%0d want 1 5", o_stable, o_bus);
    end
    tests_run++;
    if (o_stall !== 6 || o_rv !== 0 || o_to !== 0) begin
      tests_failed++; $display("FAIL sh_stall: stall=%0d rv=%0d to=%0d want 6 0 0", o_stall, o_rv, o_to);
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs[0] = 32'h3001; sizes[0] = 2'd2;
    addrs[1] = 32'h3003; sizes[1] = 2'd1;
    addrs[2] = 32'h3000; sizes[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, sizes[i], 1'b0, addrs[i], 32'h0, 32'h5555_5555, 1);
      tests_run++;
      if (o_mis !== 1 || o_bus !== 0 || o_stall !== 1 || o_rv !== 0 || o_done !== 1'b1) begin
        tests_failed++; $display("FAIL misaligned_%0d: mis=%0d bus=%0d stall=%0d rv=%0d done=%b want 1 0 1 0 1",
                                 i, o_mis, o_bus, o_stall, o_rv, o_done);
      end
    end
  endtask

  task automatic test_timeout;
    idle(2);
    use_t4 = 1'b1;
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0080, 32'h0, 32'h1234_5678, 4);
    tests_run++;
    if (o_bus !== 4 || o_to !== 0 || o_rv !== 1 || o_res !== 32'h1234_5678) begin
      tests_failed++; $display("FAIL ack_at_expiry: bus=%0d to=%0d rv=%0d data=%h want 4 0 1 12345678",
                               o_bus, o_to, o_rv, o_res);
    end
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0084, 32'h0, 32'h1234_5678, 0);
    tests_run++;
    if (o_bus !== 4 || o_to !== 1 || o_rv !== 0 || o_stall !== 5) begin
      tests_failed++; $display("FAIL timeout: bus=%0d to=%0d rv=%0d stall=%0d want 4 1 0 5", o_bus, o_to, o_rv, o_stall);
    end
    tests_run++;
    if (o_res !== 32'h0) begin
      tests_failed++; $display("FAIL timeout_data: data=%h want 00000000", o_res);
    end
    idle(2);
    use_t4 = 1'b0;
  endtask

  task automatic test_async_reset;
    idle(1);
    op_valid = 1'b1; op_store = 1'b0; op_size = 2'd2; op_unsigned = 1'b0;
    op_addr = 32'h0000_0040; bus_rdata = 32'hCAFE_F00D; bus_ack = 1'b0;
    @(posedge clock);
    @(posedge clock); #3;
    tests_run++;
    if (m_req !== 1'b1 || m_stall !== 1'b1) begin
      tests_failed++; $display("FAIL rst_pre: req=%b stall=%b want 1 1", m_req, m_stall);
    end
    reset = 1'b1; op_valid = 1'b0;
    #1;
    tests_run++;
    if (m_req !== 1'b0 || m_stall !== 1'b0) begin
      tests_failed++; $display("FAIL rst_async: req=%b stall=%b want 0 0", m_req, m_stall);
    end
    @(posedge clock); #2;
    reset = 1'b0;
    bus_ack = 1'b1;
    repeat (3) begin
      @(negedge clock);
      tests_run++;
      if (m_rv !== 1'b0 || m_req !== 1'b0 || m_stall !== 1'b0) begin
        tests_failed++; $display("FAIL rst_stray_ack: rv=%b req=%b stall=%b want 0 0 0", m_rv, m_req, m_stall);
      end
    end
    idle(1);
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 1);
    tests_run++;
    if (o_stall !== 2 || o_rv !== 1 || o_res !== 32'hCAFE_F00D) begin
      tests_failed++; $display("FAIL rst_recover: stall=%0d rv=%0d data=%h want 2 1 cafef00d", o_stall, o_rv, o_res);
    end
  endtask

  task automatic test_back_to_back;
    run_op(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 32'h0000_8001, 2);
    tests_run++;
    if (o_res !== 32'hFFFF_8001 || o_stall !== 3 || o_sel !== 4'b0011) begin
      tests_failed++; $display("FAIL b2b_first: data=%h stall=%0d sel=%b want ffff8001 3 0011", o_res, o_stall, o_sel);
    end
    run_op(1'b0, 2'd1, 1'b1, 32'h0000_0100, 32'h0, 32'h8001_0000, 1);
    tests_run++;
    if (o_res !== 32'h0000_8001 || o_stall !== 2 || o_sel !== 4'b1100) begin
      tests_failed++; $display("FAIL b2b_second: data=%h stall=%0d sel=%b want 00008001 2 1100", o_res, o_stall, o_sel);
    end
  endtask

  task automatic test_random;
    logic        st, un, e_mis, e_rv, e_to;
    logic [1:0]  sz;
    logic [31:0] addr, data, rdata, e_wdata, e_res;
    logic [3:0]  e_sel;
    int          ack_at, e_bus, e_stall, to_n;
    for (int u = 0; u < 2; u++) begin
      idle(2);
      use_t4 = (u == 1);
      to_n = (u == 1) ? 4 : 255;
      for (int n = 0; n < 30; n++) begin
        st = 1'($urandom); un = 1'($urandom);
        sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
        addr = $urandom; data = $urandom; rdata = $urandom;
        if ($urandom % 4 != 0) addr[1:0] = (sz == 2'd1) ? {addr[1], 1'b0} : (sz == 2'd2) ? 2'b00 : addr[1:0];
        ack_at = (u == 1) ? int'($urandom_range(0, 6)) : int'($urandom_range(1, 6));
        model(st, sz, un, addr, data, rdata, ack_at, to_n, e_mis, e_sel, e_wdata, e_res, e_rv, e_to, e_bus, e_stall);
        run_op(st, sz, un, addr, data, rdata, ack_at);
        tests_run++;
        if (o_done !== 1'b1 || o_stall !== e_stall || o_bus !== e_bus) begin
          tests_failed++; $display("FAIL rnd_timing[%0d.%0d]: done=%b stall=%0d bus=%0d want 1 %0d %0d",
                                   u, n, o_done, o_stall, o_bus, e_stall, e_bus);
        end
        tests_run++;
        if (o_mis !== int'(e_mis) || o_rv !== int'(e_rv) || o_to !== int'(e_to)) begin
          tests_failed++; $display("FAIL rnd_pulses[%0d.%0d]: mis=%0d rv=%0d to=%0d want %0d %0d %0d",
                                   u, n, o_mis, o_rv, o_to, e_mis, e_rv, e_to);
        end
        if (!e_mis) begin
          tests_run++;
          if ({o_addr, o_sel, o_we, o_stable} !== {addr[31:2], 2'b00, e_sel, st, 1'b1} ||
              (st && o_wdata !== e_wdata)) begin
            tests_failed++; $display("FAIL rnd_bus[%0d.%0d]: addr=%h sel=%b we=%b stable=%b wdata=%h want %h %b %b 1 %h",
                                     u, n, o_addr, o_sel, o_we, o_stable, o_wdata,
                                     {addr[31:2], 2'b00}, e_sel, st, e_wdata);
          end
        end
        if (e_rv || e_to) begin
          tests_run++;
          if (o_res !== e_res) begin
            tests_failed++; $display("FAIL rnd_data[%0d.%0d]: data=%h want %h (size=%0d addr=%h rdata=%h uns=%b)",
                                     u, n, o_res, e_res, sz, addr, rdata, un);
          end
        end
      end
    end
    idle(2);
    use_t4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_loads();
    test_half_store();
    test_misaligned();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    test_random();
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
